// File: rtl/crc32_check.sv
// Serial CRC-32 receiver/checker: recomputes the CRC over len MSB-first data bits,
// echoes the data bits, and compares the computed CRC with the 32 trailing CRC bits.
module crc32_check (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] len,
    input  logic        din,
    input  logic        din_vld,
    output logic        dout,
    output logic        dout_vld,
    output logic [31:0] crc_val,
    output logic        crc_ok,
    output logic        abort,
    output logic        done
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        vld_q;
    logic [31:0] lfsr, lfsr_nxt;
    logic [31:0] len_q, len_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [4:0]  kcnt, kcnt_nxt;
    logic        mismatch, mismatch_nxt;
    logic        dout_nxt, dout_vld_nxt, crc_ok_nxt, abort_nxt, done_nxt;
    logic [31:0] crc_val_nxt;

    logic        start;
    logic [31:0] lfsr_base, lfsr_upd;
    logic        fb;
    logic        crc_bit;

    // The start bit is processed against a fresh seed, so the LFSR step uses the seed there.
    assign start     = (state == IDLE) && din_vld && !vld_q;
    assign lfsr_base = start ? SEED : lfsr;
    assign fb        = din ^ lfsr_base[31];
    assign lfsr_upd  = {lfsr_base[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    assign crc_bit   = crc_val[5'd31 - kcnt];

    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        len_nxt      = len_q;
        cnt_nxt      = cnt;
        kcnt_nxt     = kcnt;
        mismatch_nxt = mismatch;
        dout_nxt     = dout;
        dout_vld_nxt = 1'b0;
        crc_val_nxt  = crc_val;
        crc_ok_nxt   = crc_ok;
        abort_nxt    = abort;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt      = len;
                    crc_ok_nxt   = 1'b0;
                    abort_nxt    = 1'b0;
                    mismatch_nxt = 1'b0;
                    cnt_nxt      = 32'd0;
                    kcnt_nxt     = 5'd0;
                    if (len != 32'd0) begin
                        lfsr_nxt     = lfsr_upd;
                        dout_nxt     = din;
                        dout_vld_nxt = 1'b1;
                        cnt_nxt      = 32'd1;
                        if (len == 32'd1) begin
                            crc_val_nxt = ~lfsr_upd;
                            state_nxt   = CRC;
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        // Empty frame: the start bit is CRC bit 31, checked against a zero CRC.
                        lfsr_nxt     = SEED;
                        crc_val_nxt  = 32'h0;
                        mismatch_nxt = din;
                        kcnt_nxt     = 5'd1;
                        state_nxt    = CRC;
                    end
                end else if (din_vld) begin
                    state_nxt = HOLD;
                end
            end

            DATA: begin
                if (din_vld) begin
                    lfsr_nxt     = lfsr_upd;
                    dout_nxt     = din;
                    dout_vld_nxt = 1'b1;
                    cnt_nxt      = cnt + 32'd1;
                    if (cnt + 32'd1 == len_q) begin
                        crc_val_nxt = ~lfsr_upd;
                        kcnt_nxt    = 5'd0;
                        state_nxt   = CRC;
                    end
                end else begin
                    done_nxt   = 1'b1;
                    abort_nxt  = 1'b1;
                    crc_ok_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end

            CRC: begin
                if (din_vld) begin
                    mismatch_nxt = mismatch | (din != crc_bit);
                    kcnt_nxt     = kcnt + 5'd1;
                    if (kcnt == 5'd31) begin
                        done_nxt   = 1'b1;
                        crc_ok_nxt = !mismatch_nxt;
                        abort_nxt  = 1'b0;
                        state_nxt  = IDLE;
                    end
                end else begin
                    done_nxt   = 1'b1;
                    abort_nxt  = 1'b1;
                    crc_ok_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end

            HOLD: begin
                if (!din_vld) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            vld_q    <= 1'b0;
            lfsr     <= SEED;
            len_q    <= 32'd0;
            cnt      <= 32'd0;
            kcnt     <= 5'd0;
            mismatch <= 1'b0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            crc_val  <= 32'h0;
            crc_ok   <= 1'b0;
            abort    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            vld_q    <= din_vld;
            lfsr     <= lfsr_nxt;
            len_q    <= len_nxt;
            cnt      <= cnt_nxt;
            kcnt     <= kcnt_nxt;
            mismatch <= mismatch_nxt;
            dout     <= dout_nxt;
            dout_vld <= dout_vld_nxt;
            crc_val  <= crc_val_nxt;
            crc_ok   <= crc_ok_nxt;
            abort    <= abort_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_crc32_check.sv
// Self-checking bench for crc32_check: directed frames plus random frames, checked
// against a polynomial long-division CRC model and an expected queue of echoed data bits.
module tb_crc32_check;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] len;
    logic        din;
    logic        din_vld;
    logic        dout;
    logic        dout_vld;
    logic [31:0] crc_val;
    logic        crc_ok;
    logic        abort;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [0:0] exp_q[$];

    typedef struct packed {
        logic        ok;
        logic        ab;
        logic [31:0] crc;
    } done_t;
    done_t done_q[$];

    crc32_check dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .len      (len),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .crc_val  (crc_val),
        .crc_ok   (crc_ok),
        .abort    (abort),
        .done     (done)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference CRC: mod-2 long division of the augmented message (first 32 bits
    // inverted to account for the all-ones seed), remainder inverted.
    function automatic logic [31:0] ref_crc(input bit msg[$]);
        bit          a[$];
        bit [32:0]   g;
        logic [31:0] r;
        int          n;
        g = 33'h1_04C1_1DB7;
        n = msg.size();
        a = msg;
        for (int i = 0; i < 32; i++) a.push_back(1'b0);
        for (int i = 0; i < 32; i++) a[i] = ~a[i];
        for (int i = 0; i < n; i++) begin
            if (a[i]) begin
                for (int j = 0; j <= 32; j++) a[i+j] = a[i+j] ^ g[32-j];
            end
        end
        for (int j = 0; j < 32; j++) r[31-j] = a[n+j];
        return ~r;
    endfunction

    // Scoreboard: echoed data bits and end-of-frame results.
    always @(negedge sys_clk) begin
        logic [0:0] e;
        if (dout_vld) begin
            if (exp_q.size() == 0) begin
                chk("spurious_dout_vld", {31'd0, dout_vld}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("dout", {31'd0, dout}, {31'd0, e});
            end
        end
        if (done) done_q.push_back(done_t'{crc_ok, abort, crc_val});
    end

    // Drivers
    task automatic drive_bit(input logic b, input logic [31:0] l);
        @(posedge sys_clk);
        #1;
        din     = b;
        din_vld = 1'b1;
        len     = l;
    endtask

    task automatic go_idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            din_vld = 1'b0;
            din     = 1'($urandom_range(0, 1));
            len     = $urandom;
        end
    endtask

    task automatic send_frame(input bit data[$], input logic [31:0] crc_tx, input int n_extra);
        int n;
        n = data.size();
        for (int i = 0; i < n; i++) begin
            drive_bit(data[i], (i == 0) ? 32'(n) : $urandom);
            exp_q.push_back(data[i]);
        end
        for (int k = 0; k < 32; k++) drive_bit(crc_tx[31-k], (n == 0 && k == 0) ? 32'd0 : $urandom);
        for (int x = 0; x < n_extra; x++) drive_bit(1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic expect_done(input string tag, input logic ok, input logic ab,
                               input logic [31:0] crc, input bit check_crc);
        done_t d;
        chk({tag, "_done_present"}, {31'd0, done_q.size() != 0}, 32'd1);
        if (done_q.size() != 0) begin
            d = done_q.pop_front();
            chk({tag, "_crc_ok"}, {31'd0, d.ok}, {31'd0, ok});
            chk({tag, "_abort"}, {31'd0, d.ab}, {31'd0, ab});
            if (check_crc) chk({tag, "_crc_val"}, d.crc, crc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout"}, {31'd0, dout}, 32'd0);
        chk({tag, "_dout_vld"}, {31'd0, dout_vld}, 32'd0);
        chk({tag, "_crc_val"}, crc_val, 32'd0);
        chk({tag, "_crc_ok"}, {31'd0, crc_ok}, 32'd0);
        chk({tag, "_abort"}, {31'd0, abort}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        bit          msg[$];
        bit          empty_q[$];
        bit          fa[$];
        bit          fb[$];
        bit          fr[$];
        logic [31:0] good_crc;
        logic [31:0] crc_a;
        logic [31:0] crc_b;
        logic [31:0] crc_r;
        logic [31:0] flip;
        logic [7:0]  ch;
        int          n;
        bit          bad;

        for (int c = 0; c < 9; c++) begin
            ch = 8'h31 + 8'(c);
            for (int j = 7; j >= 0; j--) msg.push_back(ch[j]);
        end
        good_crc = ref_crc(msg);

        // Reset
        sys_rst_n = 1'b0;
        din       = 1'b0;
        din_vld   = 1'b0;
        len       = 32'd0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        go_idle(2);

        // Good frame "123456789"
        send_frame(msg, good_crc, 0);
        go_idle(3);
        expect_done("good", 1'b1, 1'b0, 32'hFC89_1918, 1'b1);
        chk("good_data_drained", 32'(exp_q.size()), 32'd0);
        chk("good_crc_hold", crc_val, 32'hFC89_1918);

        // Corrupt CRC bit 5
        send_frame(msg, good_crc ^ 32'h0000_0020, 0);
        go_idle(3);
        expect_done("corrupt", 1'b0, 1'b0, 32'hFC89_1918, 1'b1);

        // Empty frame
        send_frame(empty_q, 32'h0, 0);
        go_idle(3);
        expect_done("empty", 1'b1, 1'b0, 32'h0, 1'b1);
        chk("empty_model", ref_crc(empty_q), 32'h0);

        // Early drop after 40 data bits
        for (int i = 0; i < 40; i++) begin
            drive_bit(msg[i], (i == 0) ? 32'd72 : $urandom);
            exp_q.push_back(msg[i]);
        end
        go_idle(1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("drop_done", {31'd0, done}, 32'd1);
        chk("drop_abort", {31'd0, abort}, 32'd1);
        chk("drop_crc_ok", {31'd0, crc_ok}, 32'd0);
        go_idle(3);
        expect_done("drop", 1'b0, 1'b1, 32'h0, 1'b0);
        chk("drop_done_single", 32'(done_q.size()), 32'd0);

        // Back-to-back frames, then din_vld held for 3 extra bits
        n = $urandom_range(8, 48);
        for (int i = 0; i < n; i++) fa.push_back(1'($urandom_range(0, 1)));
        n = $urandom_range(8, 48);
        for (int i = 0; i < n; i++) fb.push_back(1'($urandom_range(0, 1)));
        crc_a = ref_crc(fa);
        crc_b = ref_crc(fb);
        send_frame(fa, crc_a, 0);
        go_idle(1);
        send_frame(fb, crc_b, 3);
        go_idle(4);
        expect_done("b2b_a", 1'b1, 1'b0, crc_a, 1'b1);
        expect_done("b2b_b", 1'b1, 1'b0, crc_b, 1'b1);
        chk("b2b_no_extra_done", 32'(done_q.size()), 32'd0);

        // Random frames, some with a corrupted CRC bit
        repeat (6) begin
            fr.delete();
            n = $urandom_range(0, 64);
            for (int i = 0; i < n; i++) fr.push_back(1'($urandom_range(0, 1)));
            crc_r = ref_crc(fr);
            bad   = 1'($urandom_range(0, 1));
            flip  = bad ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            send_frame(fr, crc_r ^ flip, $urandom_range(0, 2));
            go_idle($urandom_range(1, 3));
            expect_done("rand", !bad, 1'b0, crc_r, 1'b1);
        end

        // Mid-frame reset at data bit 20
        for (int i = 0; i < 20; i++) begin
            drive_bit(msg[i], (i == 0) ? 32'd72 : $urandom);
            exp_q.push_back(msg[i]);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        din_vld   = 1'b0;
        #1;
        check_all_zero("midreset");
        chk("midreset_data_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        go_idle(3);
        chk("midreset_no_done", 32'(done_q.size()), 32'd0);
        send_frame(msg, good_crc, 0);
        go_idle(3);
        expect_done("post_reset", 1'b1, 1'b0, 32'hFC89_1918, 1'b1);

        // Final report
        chk("final_data_drained", 32'(exp_q.size()), 32'd0);
        chk("final_done_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
